// File: rtl/display_pager.sv
// Order-book display pager: selects which values drive the HEX display slots,
// with button/timer page rotation, a halt page, and a stretched trade LED.
// Build option DISPLAY_PAGER_SNAPSHOT_EN adds the SNAP page and its capture registers.
module display_pager #(
  parameter int ROTATE_TICKS  = 150000000,
  parameter int STRETCH_TICKS = 5000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] buy_price,
  input  logic [7:0] sell_price,
  input  logic [7:0] spread_now,
  input  logic [7:0] trade_count,
  input  logic       halt_flag,
  input  logic       match_flag,
  input  logic       next_page,
  input  logic       auto_en,
  output logic [7:0] disp_a,
  output logic [7:0] disp_b,
  output logic [7:0] disp_c,
  output logic [1:0] page,
  output logic       match_led
);

  localparam int DW = $clog2(ROTATE_TICKS + 1);
  localparam int SW = $clog2(STRETCH_TICKS + 1);
  localparam logic [DW-1:0] DWELL_LAST   = DW'(ROTATE_TICKS - 1);
  localparam logic [SW-1:0] STRETCH_LOAD = SW'(STRETCH_TICKS);

  typedef enum logic [1:0] {
    PRICES = 2'd0,
    COUNT  = 2'd1,
    SNAP   = 2'd2,
    HALT   = 2'd3
  } state_t;

  state_t        state, state_next;
  logic [DW-1:0] dwell, dwell_next;
  logic [SW-1:0] stretch, stretch_next;
  logic          next_prev, match_prev;
  logic          next_rise, match_rise, dwell_done;
  logic [7:0]    disp_a_next, disp_b_next, disp_c_next;

  assign next_rise  = next_page & ~next_prev;
  assign match_rise = match_flag & ~match_prev;
  // Dwell only counts outside HALT; the HALT branch below never consults it.
  assign dwell_done = auto_en && (dwell == DWELL_LAST);
  assign page       = state;

  function automatic state_t advance(input state_t s);
    case (s)
      PRICES: advance = COUNT;
`ifdef DISPLAY_PAGER_SNAPSHOT_EN
      COUNT:  advance = SNAP;
`else
      COUNT:  advance = PRICES;
`endif
      default: advance = PRICES;
    endcase
  endfunction

  always_comb begin
    state_next = state;
    dwell_next = dwell;
    if (halt_flag) begin
      state_next = HALT;
      dwell_next = '0;
    end else if (state == HALT) begin
      state_next = PRICES;
      dwell_next = '0;
    end else if (next_rise || dwell_done) begin
      state_next = advance(state);
      dwell_next = '0;
    end else if (auto_en) begin
      dwell_next = dwell + DW'(1);
    end else begin
      dwell_next = '0;
    end
  end

  always_comb begin
    stretch_next = stretch;
    if (match_rise) begin
      stretch_next = STRETCH_LOAD;
    end else if (stretch != '0) begin
      stretch_next = stretch - SW'(1);
    end
  end

`ifdef DISPLAY_PAGER_SNAPSHOT_EN
  logic [7:0] snap_buy, snap_sell, snap_count;
  logic [7:0] snap_buy_next, snap_sell_next, snap_count_next;

  always_comb begin
    snap_buy_next   = snap_buy;
    snap_sell_next  = snap_sell;
    snap_count_next = snap_count;
    if (match_rise) begin
      snap_buy_next   = buy_price;
      snap_sell_next  = sell_price;
      snap_count_next = trade_count;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      snap_buy   <= '0;
      snap_sell  <= '0;
      snap_count <= '0;
    end else begin
      snap_buy   <= snap_buy_next;
      snap_sell  <= snap_sell_next;
      snap_count <= snap_count_next;
    end
  end
`endif

  // Display content follows the page being entered, so page and disp_* always agree.
  always_comb begin
    disp_a_next = '0;
    disp_b_next = '0;
    disp_c_next = '0;
    case (state_next)
      PRICES: begin
        disp_a_next = buy_price;
        disp_b_next = sell_price;
        disp_c_next = spread_now;
      end
      COUNT: disp_a_next = trade_count;
`ifdef DISPLAY_PAGER_SNAPSHOT_EN
      SNAP: begin
        disp_a_next = snap_buy_next;
        disp_b_next = snap_sell_next;
        disp_c_next = snap_count_next;
      end
`endif
      HALT: begin
        disp_a_next = 8'hFF;
        disp_b_next = 8'hFF;
        disp_c_next = trade_count;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= PRICES;
      dwell      <= '0;
      stretch    <= '0;
      next_prev  <= 1'b0;
      match_prev <= 1'b0;
      disp_a     <= '0;
      disp_b     <= '0;
      disp_c     <= '0;
      match_led  <= 1'b0;
    end else begin
      state      <= state_next;
      dwell      <= dwell_next;
      stretch    <= stretch_next;
      next_prev  <= next_page;
      match_prev <= match_flag;
      disp_a     <= disp_a_next;
      disp_b     <= disp_b_next;
      disp_c     <= disp_c_next;
      match_led  <= (stretch_next != '0);
    end
  end

endmodule

// File: tb/tb_display_pager.sv
// Bench for display_pager: directed vector table, hand-written multi-cycle
// sequences, then random stimulus compared against a page-list reference model.
module tb_display_pager;

  localparam int ROT = 4;
  localparam int STR = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] buy_price = '0, sell_price = '0, spread_now = '0, trade_count = '0;
  logic       halt_flag = 1'b0, match_flag = 1'b0, next_page = 1'b0, auto_en = 1'b0;
  logic [7:0] disp_a, disp_b, disp_c;
  logic [1:0] page;
  logic       match_led;

  int n_checks = 0;
  int n_fail   = 0;

  display_pager #(.ROTATE_TICKS(ROT), .STRETCH_TICKS(STR)) dut (
    .clk(clk), .reset(reset),
    .buy_price(buy_price), .sell_price(sell_price),
    .spread_now(spread_now), .trade_count(trade_count),
    .halt_flag(halt_flag), .match_flag(match_flag),
    .next_page(next_page), .auto_en(auto_en),
    .disp_a(disp_a), .disp_b(disp_b), .disp_c(disp_c),
    .page(page), .match_led(match_led)
  );

  always #5 clk = ~clk;

`ifdef DISPLAY_PAGER_SNAPSHOT_EN
  localparam bit SNAP_EN = 1'b1;
`else
  localparam bit SNAP_EN = 1'b0;
`endif

  // Reference model: rotation is a list of pages; counters are plain integers.
  int         rot_list[$];
  int         m_page, m_dwell, m_stretch;
  int         m_prev_next, m_prev_match;
  logic [7:0] m_snap[3];
  logic [7:0] m_a, m_b, m_c;
  logic       m_led;

  task automatic model_step();
    int idx;
    bit rise_n, rise_m;
    if (reset) begin
      m_page = 0; m_dwell = 0; m_stretch = 0;
      m_prev_next = 0; m_prev_match = 0;
      m_snap[0] = 0; m_snap[1] = 0; m_snap[2] = 0;
      m_a = 0; m_b = 0; m_c = 0; m_led = 0;
      return;
    end
    rise_n = next_page && (m_prev_next == 0);
    rise_m = match_flag && (m_prev_match == 0);
    if (rise_m) begin
      if (SNAP_EN) begin
        m_snap[0] = buy_price; m_snap[1] = sell_price; m_snap[2] = trade_count;
      end
      m_stretch = STR;
    end else if (m_stretch > 0) begin
      m_stretch--;
    end
    if (halt_flag) begin
      m_page = 3; m_dwell = 0;
    end else if (m_page == 3) begin
      m_page = 0; m_dwell = 0;
    end else begin
      m_dwell = auto_en ? m_dwell + 1 : 0;
      if (rise_n || m_dwell == ROT) begin
        idx = 0;
        foreach (rot_list[i]) if (rot_list[i] == m_page) idx = i;
        m_page = rot_list[(idx + 1) % rot_list.size()];
        m_dwell = 0;
      end
    end
    m_prev_next  = next_page;
    m_prev_match = match_flag;
    m_led = (m_stretch > 0);
    case (m_page)
      0: begin m_a = buy_price; m_b = sell_price; m_c = spread_now; end
      1: begin m_a = trade_count; m_b = 0; m_c = 0; end
      2: begin m_a = m_snap[0]; m_b = m_snap[1]; m_c = m_snap[2]; end
      default: begin m_a = 8'hFF; m_b = 8'hFF; m_c = trade_count; end
    endcase
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; halt_flag = 0; match_flag = 0; next_page = 0; auto_en = 0;
    step();
    reset = 1'b0;
  endtask

  typedef struct {
    logic       rst;
    logic [7:0] buy, sell, spr, cnt;
    logic       halt, match, nxt;
    logic [1:0] e_page;
    logic [7:0] e_a, e_b, e_c;
    logic       e_led;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic [7:0] buy, sell, spr, cnt,
                              logic halt, match, nxt,
                              logic [1:0] e_page, logic [7:0] e_a, e_b, e_c, logic e_led);
    vec_t v;
    v.rst = rst; v.buy = buy; v.sell = sell; v.spr = spr; v.cnt = cnt;
    v.halt = halt; v.match = match; v.nxt = nxt;
    v.e_page = e_page; v.e_a = e_a; v.e_b = e_b; v.e_c = e_c; v.e_led = e_led;
    return v;
  endfunction

  initial begin
    logic [1:0] p16;
    logic [7:0] a16, b16, c16;
    int exp_pg;

    if (SNAP_EN) rot_list = '{0, 1, 2};
    else rot_list = '{0, 1};
    if (SNAP_EN) begin p16 = 2; a16 = 8'h10; b16 = 8'h10; c16 = 8'h07; end
    else begin p16 = 0; a16 = 8'h20; b16 = 8'h30; c16 = 8'h03; end

    // Directed table, auto_en held low.
    vecs.push_back(mk(1, 8'h42, 8'h45, 8'h03, 8'h07, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0));
    vecs.push_back(mk(0, 8'h42, 8'h45, 8'h03, 8'h07, 0, 0, 0, 0, 8'h42, 8'h45, 8'h03, 0));
    vecs.push_back(mk(0, 8'h42, 8'h45, 8'h03, 8'h07, 0, 0, 1, 1, 8'h07, 8'h00, 8'h00, 0));
    vecs.push_back(mk(0, 8'h42, 8'h45, 8'h03, 8'h07, 0, 0, 1, 1, 8'h07, 8'h00, 8'h00, 0));
    vecs.push_back(mk(0, 8'h42, 8'h45, 8'h03, 8'h07, 0, 0, 0, 1, 8'h07, 8'h00, 8'h00, 0));
    vecs.push_back(mk(0, 8'h42, 8'h45, 8'h03, 8'h07, 1, 0, 0, 3, 8'hFF, 8'hFF, 8'h07, 0));
    vecs.push_back(mk(0, 8'h42, 8'h45, 8'h03, 8'h07, 1, 0, 1, 3, 8'hFF, 8'hFF, 8'h07, 0));
    vecs.push_back(mk(0, 8'h42, 8'h45, 8'h03, 8'h07, 0, 0, 1, 0, 8'h42, 8'h45, 8'h03, 0));
    vecs.push_back(mk(0, 8'h10, 8'h10, 8'h03, 8'h07, 0, 1, 0, 0, 8'h10, 8'h10, 8'h03, 1));
    vecs.push_back(mk(0, 8'h10, 8'h10, 8'h03, 8'h07, 0, 1, 0, 0, 8'h10, 8'h10, 8'h03, 1));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0, 8'h20, 8'h30, 8'h03, 8'h09, 0, 0, 0, 0, 8'h20, 8'h30, 8'h03, 1));
    vecs.push_back(mk(0, 8'h20, 8'h30, 8'h03, 8'h09, 0, 0, 0, 0, 8'h20, 8'h30, 8'h03, 0));
    vecs.push_back(mk(0, 8'h20, 8'h30, 8'h03, 8'h09, 0, 0, 1, 1, 8'h09, 8'h00, 8'h00, 0));
    vecs.push_back(mk(0, 8'h20, 8'h30, 8'h03, 8'h09, 0, 0, 0, 1, 8'h09, 8'h00, 8'h00, 0));
    vecs.push_back(mk(0, 8'h20, 8'h30, 8'h03, 8'h09, 0, 0, 1, p16, a16, b16, c16, 0));
    vecs.push_back(mk(1, 8'h20, 8'h30, 8'h03, 8'h09, 1, 1, 1, 0, 8'h00, 8'h00, 8'h00, 0));

    foreach (vecs[i]) begin
      reset = vecs[i].rst; buy_price = vecs[i].buy; sell_price = vecs[i].sell;
      spread_now = vecs[i].spr; trade_count = vecs[i].cnt;
      halt_flag = vecs[i].halt; match_flag = vecs[i].match; next_page = vecs[i].nxt;
      auto_en = 1'b0;
      step();
      check($sformatf("vec%0d_page", i), page, vecs[i].e_page);
      check($sformatf("vec%0d_a", i), disp_a, vecs[i].e_a);
      check($sformatf("vec%0d_b", i), disp_b, vecs[i].e_b);
      check($sformatf("vec%0d_c", i), disp_c, vecs[i].e_c);
      check($sformatf("vec%0d_led", i), match_led, vecs[i].e_led);
    end

    // Button held for 10 clocks advances exactly once.
    do_reset();
    trade_count = 8'h5A;
    next_page = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("hold_page", page, 1);
    end
    next_page = 1'b0;
    step();
    check("hold_rel_page", page, 1);
    check("hold_rel_a", disp_a, 8'h5A);
    check("hold_rel_b", disp_b, 8'h00);
    check("hold_rel_c", disp_c, 8'h00);

    // Timed rotation; button edge lands on the terminal cycle of the second dwell.
    do_reset();
    auto_en = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      if (e == 8) next_page = 1'b1;
      step();
      exp_pg = rot_list[(e / ROT) % rot_list.size()];
      check($sformatf("rot_e%0d", e), page, exp_pg);
    end
    next_page = 1'b0;

    // Reset mid-dwell while the trade LED is lit.
    do_reset();
    auto_en = 1'b1;
    match_flag = 1'b1;
    step();
    match_flag = 1'b0;
    step();
    step();
    check("pre_rst_led", match_led, 1);
    reset = 1'b1;
    step();
    check("mid_rst_page", page, 0);
    check("mid_rst_a", disp_a, 0);
    check("mid_rst_b", disp_b, 0);
    check("mid_rst_c", disp_c, 0);
    check("mid_rst_led", match_led, 0);
    reset = 1'b0;
    buy_price = 8'h33; sell_price = 8'h34; spread_now = 8'h01;
    step();
    check("post_rst_a", disp_a, 8'h33);
    check("post_rst_c", disp_c, 8'h01);
    step(); step();
    check("post_rst_dwell3", page, 0);
    step();
    check("post_rst_dwell4", page, 1);

    // Randomised run against the reference model.
    do_reset();
    auto_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 40) == 0) halt_flag = ~halt_flag;
      if ($urandom_range(0, 3) == 0) next_page = ~next_page;
      if ($urandom_range(0, 5) == 0) match_flag = ~match_flag;
      if ($urandom_range(0, 60) == 0) auto_en = ~auto_en;
      buy_price = 8'($urandom); sell_price = 8'($urandom);
      spread_now = 8'($urandom); trade_count = 8'($urandom);
      step();
      check("rnd_page", page, m_page);
      check("rnd_a", disp_a, m_a);
      check("rnd_b", disp_b, m_b);
      check("rnd_c", disp_c, m_c);
      check("rnd_led", match_led, m_led);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/display_pager.md
DISPLAY_PAGER -- requirements
Module: display_pager

Interface
REQ-001 SHALL have parameter ROTATE_TICKS, default 150000000: clocks per auto-rotate page dwell (3 s at 50 MHz).
REQ-002 SHALL have parameter STRETCH_TICKS, default 5000000: clocks match_led stays high after a trade (100 ms).
REQ-003 SHALL have port clk  in  1: single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  in  1: synchronous, active-high reset.
REQ-005 SHALL have ports buy_price, sell_price, spread_now, trade_count  in  8 each: live order-book values.
REQ-006 SHALL have ports halt_flag, match_flag  in  1 each: system halt level; trade-match indication (may be multi-cycle).
REQ-007 SHALL have port next_page  in  1: synchronized, debounced, active-high button level.
REQ-008 SHALL have port auto_en  in  1: enables timed page rotation.
REQ-009 SHALL have ports disp_a, disp_b, disp_c  out  8 each: values routed to the buy, sell and spread slots of the HEX display driver.
REQ-010 SHALL have ports page  out  2 (current page code) and match_led  out  1 (stretched trade indicator).

Function
REQ-011 SHALL implement the FSM states PRICES=0, COUNT=1, SNAP=2, HALT=3; page equals the state code.
REQ-012 SHALL map the pages as follows: PRICES a/b/c = buy/sell/spread; COUNT = trade_count/00/00; SNAP = snap_buy/snap_sell/snap_count; HALT = FF/FF/trade_count.
REQ-013 SHALL register all outputs, so an input change appears on disp_* exactly 1 clock later.
REQ-014 SHALL advance the page exactly once per 0->1 edge of next_page, following PRICES->COUNT->SNAP->PRICES.
REQ-015 SHALL keep a dwell counter, 0..ROTATE_TICKS-1, that runs only while auto_en=1 and state!=HALT; on terminal count it advances the page as in REQ-014 and wraps to 0.
REQ-016 SHALL clear the dwell counter on every page change and while auto_en=0.
REQ-017 SHALL, when a next_page edge and the dwell terminal count occur in the same cycle, advance once only and clear the counter.
REQ-018 SHALL enter HALT on the clock after halt_flag=1 is sampled, from any state, ignoring next_page and the timer.
REQ-019 SHALL return to PRICES with a cleared dwell counter on the clock after halt_flag=0 is sampled while in HALT.
REQ-020 SHALL capture buy_price, sell_price and trade_count into snap_buy/snap_sell/snap_count on each 0->1 edge of match_flag, including while in HALT.
REQ-021 SHALL load the stretch counter with STRETCH_TICKS on each match_flag rising edge (retrigger restarts it); match_led=1 while the counter is nonzero.
REQ-022 SHALL size counters to $clog2(parameter+1) bits; they shall not wrap past their terminal value.

Reset
REQ-023 SHALL, on reset=1 at a clock edge, set state=PRICES, page=0, disp_a/b/c=00, match_led=0, clear the dwell and stretch counters, clear snap registers to 00, and clear edge-detect history to 0.
REQ-024 SHALL ensure reset takes priority over halt_flag, next_page, match_flag and timer events in the same cycle.
REQ-025 SHALL resume normal operation on the first clock after reset deasserts, showing live prices 1 clock later.

Configuration
REQ-026 SHALL recognise macro DISPLAY_PAGER_SNAPSHOT_EN: when defined, the SNAP page and the snap registers exist as specified.
REQ-027 SHALL, without DISPLAY_PAGER_SNAPSHOT_EN, make rotation PRICES->COUNT->PRICES, never reach state SNAP, and remove the snap registers; match_led is unaffected.

Verification
REQ-028 SHALL cover scenario: reset, buy=0x42, sell=0x45, spread=0x03 -> 1 clock later disp=42/45/03, page=0.
REQ-029 SHALL cover scenario: next_page held high 10 clocks, then low -> exactly one advance, page=1, disp=trade_count/00/00.
REQ-030 SHALL cover scenario: ROTATE_TICKS=4, auto_en=1 -> page 0->1->2->0 every 4 clocks; a next_page edge on a terminal cycle -> single advance.
REQ-031 SHALL cover scenario: halt_flag=1 while on COUNT -> page=3, disp=FF/FF/count next clock; halt_flag=0 -> page=0.
REQ-032 SHALL cover scenario: STRETCH_TICKS=5, match pulse with buy=0x10, sell=0x10, count=0x07 -> match_led high 5 clocks; SNAP shows 10/10/07; with the macro undefined, SNAP is never reached.
REQ-033 SHALL cover scenario: reset asserted mid-dwell with match_led=1 -> all outputs at reset values next clock.
